// File: rtl/crc_job_sequencer.sv
// Purpose: host-programmed job controller that streams 64-bit words from memory into the checksum engine and captures its result.
// Latency: per word one fetch + read latency + one push cycle; the result lands two cycles after eng_irq; csr_readdata has 1-cycle latency.
// Backpressure: read requests hold address/strobe while rd_waitrequest=1; one read in flight; engine writes never stall.
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   csr_address/write/writedata/read   CSR slave (0 SRC, 1 LEN, 2 CTRL, 3 STATUS, 4 RESULT)
//   csr_readdata                       registered CSR read data
//   irq                                level interrupt: irq_en & (done | len_err | timeout)
//   rd_*                               Avalon-MM read master toward memory
//   eng_*                              checksum engine slave port and its done interrupt
module crc_job_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        csr_address,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] rd_address,
    output logic              rd_read,
    input  logic              rd_waitrequest,
    input  logic [63:0]       rd_readdata,
    input  logic              rd_readdatavalid,
    output logic [9:0]        eng_address,
    output logic              eng_write,
    output logic [63:0]       eng_writedata,
    output logic              eng_read,
    input  logic [63:0]       eng_readdata,
    input  logic              eng_irq
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_FETCH, S_WAITDATA, S_PUSH,
        S_WAIT_IRQ, S_SETTLE, S_CAPTURE, S_DONE
    } state_t;

    state_t             state;
    logic [31:0]        src_q;
    logic [LEN_W-1:0]   len_q;
    logic               irq_en;
    logic               done_f;
    logic               len_err_f;
    logic               timeout_f;
    logic [31:0]        result_q;
    logic [ADDR_W-1:0]  ptr;
    logic [LEN_W-1:0]   remaining;
    logic [TMR_W-1:0]   timer;
    // Set when an abort leaves a read in flight; its data beat must be swallowed.
    logic               drop_pending;

    logic               busy;
    logic               wr_src, wr_len, wr_ctrl, wr_status;
    logic               ctrl_start, ctrl_abort;
    logic [31:0]        rd_mux;
    logic               unused_eng_hi;

    assign busy       = !(state == S_IDLE || state == S_DONE);
    assign wr_src     = csr_write && (csr_address == 3'd0);
    assign wr_len     = csr_write && (csr_address == 3'd1);
    assign wr_ctrl    = csr_write && (csr_address == 3'd2);
    assign wr_status  = csr_write && (csr_address == 3'd3);
    // Abort beats start when both are in one write.
    assign ctrl_start = wr_ctrl && csr_writedata[0] && !csr_writedata[2];
    assign ctrl_abort = wr_ctrl && csr_writedata[2];
    assign unused_eng_hi = ^eng_readdata[63:32];

    always_comb begin
        rd_mux = 32'h0;
        case (csr_address)
            3'd0:    rd_mux = src_q;
            3'd1:    rd_mux = 32'(len_q);
            3'd2:    rd_mux = {30'h0, irq_en, 1'b0};
            3'd3:    rd_mux = {28'h0, timeout_f, len_err_f, done_f, busy};
            3'd4:    rd_mux = result_q;
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            src_q         <= '0;
            len_q         <= '0;
            irq_en        <= 1'b0;
            done_f        <= 1'b0;
            len_err_f     <= 1'b0;
            timeout_f     <= 1'b0;
            result_q      <= '0;
            ptr           <= '0;
            remaining     <= '0;
            timer         <= '0;
            drop_pending  <= 1'b0;
            csr_readdata  <= '0;
            irq           <= 1'b0;
            rd_address    <= '0;
            rd_read       <= 1'b0;
            eng_address   <= '0;
            eng_write     <= 1'b0;
            eng_writedata <= '0;
            eng_read      <= 1'b0;
        end else begin
            if (csr_read)
                csr_readdata <= rd_mux;
            if (wr_src && !busy)
                src_q <= csr_writedata;
            if (wr_len && !busy)
                len_q <= LEN_W'(csr_writedata);
            if (wr_ctrl)
                irq_en <= csr_writedata[1];
            // W1C first; any flag set later in this block overrides the clear.
            if (wr_status) begin
                if (csr_writedata[1]) done_f    <= 1'b0;
                if (csr_writedata[2]) len_err_f <= 1'b0;
                if (csr_writedata[3]) timeout_f <= 1'b0;
            end
            irq <= irq_en && (done_f || len_err_f || timeout_f);
            if (rd_readdatavalid)
                drop_pending <= 1'b0;

            eng_write <= 1'b0;
            eng_read  <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (ctrl_start) begin
                        done_f    <= 1'b0;
                        len_err_f <= 1'b0;
                        timeout_f <= 1'b0;
                        ptr       <= ADDR_W'(src_q);
                        remaining <= len_q;
                        if (len_q == '0) begin
                            len_err_f <= 1'b1;
                            result_q  <= '0;
                            state     <= S_DONE;
                        end else begin
                            state         <= S_LOAD;
                            eng_write     <= 1'b1;
                            eng_address   <= 10'h200;
                            eng_writedata <= 64'(len_q);
                        end
                    end
                end
                S_LOAD: begin
                    state      <= S_FETCH;
                    rd_read    <= 1'b1;
                    rd_address <= ptr;
                end
                S_FETCH: begin
                    if (!rd_waitrequest) begin
                        rd_read <= 1'b0;
                        state   <= S_WAITDATA;
                    end
                end
                S_WAITDATA: begin
                    if (rd_readdatavalid && !drop_pending) begin
                        state         <= S_PUSH;
                        eng_write     <= 1'b1;
                        eng_address   <= 10'h000;
                        eng_writedata <= rd_readdata;
                    end
                end
                S_PUSH: begin
                    ptr       <= ptr + ADDR_W'(8);
                    remaining <= remaining - LEN_W'(1);
                    if (remaining > LEN_W'(1)) begin
                        state      <= S_FETCH;
                        rd_read    <= 1'b1;
                        rd_address <= ptr + ADDR_W'(8);
                    end else begin
                        state <= S_WAIT_IRQ;
                        // Timer holds cycles elapsed since the last push.
                        timer <= TMR_W'(1);
                    end
                end
                S_WAIT_IRQ: begin
                    if (eng_irq) begin
                        state <= S_SETTLE;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        timeout_f <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_SETTLE: begin
                    // Engine accumulator output trails its irq by one cycle.
                    state    <= S_CAPTURE;
                    eng_read <= 1'b1;
                end
                S_CAPTURE: begin
                    result_q <= eng_readdata[31:0];
                    done_f   <= 1'b1;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase

            if (ctrl_abort && busy) begin
                state     <= S_IDLE;
                rd_read   <= 1'b0;
                eng_write <= 1'b0;
                eng_read  <= 1'b0;
                done_f    <= 1'b0;
                timeout_f <= 1'b0;
                if ((state == S_WAITDATA && !rd_readdatavalid) ||
                    (state == S_FETCH && !rd_waitrequest))
                    drop_pending <= 1'b1;
            end
        end
    end

endmodule
